// File: rtl/cpld_bus_pkg.sv
// cpld_bus_pkg: op encodings, FSM state codes and small op helpers for the CPLD bus master
package cpld_bus_pkg;
  localparam logic [1:0] OP_WR_ADDR = 2'd0;
  localparam logic [1:0] OP_WR_DATA = 2'd1;
  localparam logic [1:0] OP_RD_DATA = 2'd2;
  localparam logic [1:0] OP_RD_ADDR = 2'd3;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_STROBE = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] R_TURN1  = 3'd4;
  localparam logic [2:0] R_WIN    = 3'd5;
  localparam logic [2:0] R_TURN2  = 3'd6;
  function automatic logic is_addr_op(input logic [1:0] op);
    return op == OP_WR_ADDR || op == OP_RD_ADDR;
  endfunction
  function automatic logic is_read_op(input logic [1:0] op);
    return op == OP_RD_DATA || op == OP_RD_ADDR;
  endfunction
endpackage

// File: rtl/cpld_bus_if.sv
// cpld_bus_if: CPLD parallel register bus pins (data_rw/data_ready/data_addr/data_io/pulse_buffer_empty)
interface cpld_bus_if;
  logic        rw;
  logic        ready;
  logic        addr;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] data_in;
  logic        buffer_empty;
  modport master (output rw, ready, addr, data_out, data_oe, input data_in, buffer_empty);
  modport slave  (input rw, ready, addr, data_out, data_oe, output data_in, buffer_empty);
endinterface

// File: rtl/cpld_bus_sync.sv
// cpld_bus_sync: 2-flop synchroniser plus registered rising-edge pulse
module cpld_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [2:0] s;
  // s[1:0] synchronise, s[2] remembers the previous synchronised level
  always_ff @(posedge clk)
    if (rst) begin
      s     <= '0;
      pulse <= 1'b0;
    end else begin
      s     <= {s[1:0], d};
      pulse <= s[1] & ~s[2];
    end
endmodule

// File: rtl/cpld_bus_master.sv
// cpld_bus_master: turns single-word commands into timed CPLD bus cycles and raises irq on buffer empty
module cpld_bus_master
  import cpld_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned TURN_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_data,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  cpld_bus_if.master        bus,
  output logic              irq
);
  // the read window spans setup+strobe, which can exceed 255, so one extra counter bit
  localparam logic [8:0] LD_SETUP  = 9'(SETUP_CYCLES - 1);
  localparam logic [8:0] LD_STROBE = 9'(STROBE_CYCLES - 1);
  localparam logic [8:0] LD_HOLD   = 9'(HOLD_CYCLES - 1);
  localparam logic [8:0] LD_TURN   = 9'(TURN_CYCLES - 1);
  localparam logic [8:0] LD_WIN    = 9'(SETUP_CYCLES + STROBE_CYCLES - 1);
  logic [2:0]  state;
  logic [8:0]  cnt;
  logic        addr_q;
  logic [15:0] data_q;
  logic        last;
  assign last = cnt == '0;
  // phase sequencer: counter is loaded with (length-1) on entry, phase ends when it reaches 0
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= 1'b0;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= last ? '0 : cnt - 9'd1;
      case (state)
        IDLE:
          if (cmd_valid) begin
            addr_q <= is_addr_op(cmd_op);
            if (is_read_op(cmd_op)) begin
              state <= R_TURN1;
              cnt   <= LD_TURN;
            end else begin
              data_q <= cmd_data;
              state  <= W_SETUP;
              cnt    <= LD_SETUP;
            end
          end
        W_SETUP:
          if (last) begin
            state <= W_STROBE;
            cnt   <= LD_STROBE;
          end
        W_STROBE:
          if (last) begin
            state <= W_HOLD;
            cnt   <= LD_HOLD;
          end
        W_HOLD:
          if (last) state <= IDLE;
        R_TURN1:
          if (last) begin
            state <= R_WIN;
            cnt   <= LD_WIN;
          end
        R_WIN:
          if (last) begin
            state     <= R_TURN2;
            cnt       <= LD_TURN;
            rsp_valid <= 1'b1;
            rsp_data  <= bus.data_in;
          end
        R_TURN2:
          if (last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // pin levels are pure functions of the phase; only R_WIN hands the bus to the CPLD
  assign cmd_ready    = state == IDLE;
  assign bus.rw       = state != R_WIN;
  assign bus.ready    = state == W_STROBE;
  assign bus.data_oe  = state == W_SETUP || state == W_STROBE || state == W_HOLD;
  assign bus.addr     = addr_q;
  assign bus.data_out = data_q;
  cpld_bus_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.buffer_empty),
    .pulse(irq)
  );
endmodule

// File: tb/tb_cpld_bus_master.sv
// tb_cpld_bus_master: randomized self-checking bench with a behavioural CPLD responder
module tb_cpld_bus_master;
  import cpld_bus_pkg::*;
  localparam int S = 2, T = 4, H = 2, TU = 2;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [15:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, irq;
  logic [15:0] rsp_data;
  int tests = 0, fails = 0, contention = 0;
  cpld_bus_if bus();
  cpld_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H), .TURN_CYCLES(TU)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .bus(bus), .irq(irq)
  );
  always #5 clk = ~clk;
  // CPLD responder: address register plus register file, register 0 is the read-only device ID
  logic [15:0] cpld_addr = '0;
  logic [15:0] cpld_mem [256];
  logic ready_q = 1'b0;
  always @(posedge clk) begin
    ready_q <= bus.ready;
    if (bus.ready && !ready_q) begin
      if (bus.addr) cpld_addr <= bus.data_out;
      else if (cpld_addr[7:0] != 8'd0) cpld_mem[cpld_addr[7:0]] <= bus.data_out;
    end
  end
  assign bus.data_in = bus.rw ? 16'hBEEF : (bus.addr ? cpld_addr : (cpld_addr[7:0] == 8'd0 ? 16'h0001 : cpld_mem[cpld_addr[7:0]]));
  always @(negedge clk) if (bus.data_oe && !bus.rw) contention++;
  // reference model: what the CPLD should hold after each completed command
  logic [15:0] ref_addr = '0;
  logic [15:0] ref_mem [256];
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return a[7:0] == 8'd0 ? 16'h0001 : ref_mem[a[7:0]];
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] d, input string nm);
    logic rd;
    logic ao;
    int len;
    int w;
    logic [15:0] exp_rsp;
    logic [5:0] got, exp;
    rd = op >= 2'd2;
    ao = op == 2'd0 || op == 2'd3;
    len = rd ? 2 * TU + S + T : S + T + H;
    w = 0;
    while (!cmd_ready && w < 50) begin
      step;
      w++;
    end
    tests++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL %s idle: cmd_ready=%b required 1", nm, cmd_ready);
      return;
    end
    exp_rsp = op == OP_RD_ADDR ? ref_addr : ref_rd(ref_addr);
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    step;
    for (int k = 1; k <= len + 1; k++) begin
      cmd_valid = k < len ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_op = 2'($urandom);
      cmd_data = 16'($urandom);
      exp = {k == len + 1,
             rd ? !(k > TU && k <= TU + S + T) : 1'b1,
             !rd && k > S && k <= S + T,
             ao,
             !rd && k <= len,
             rd && k == TU + S + T + 1};
      got = {cmd_ready, bus.rw, bus.ready, bus.addr, bus.data_oe, rsp_valid};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s cycle %0d {ready,rw,strobe,addr,oe,rsp_valid}: got %b required %b", nm, k, got, exp);
      end
      if (bus.data_oe) begin
        tests++;
        if (bus.data_out !== d) begin
          fails++;
          $display("FAIL %s cycle %0d data_out: got %h required %h", nm, k, bus.data_out, d);
        end
      end
      if (k <= len) step;
    end
    if (rd) begin
      tests++;
      if (rsp_data !== exp_rsp) begin
        fails++;
        $display("FAIL %s rsp_data: got %h required %h", nm, rsp_data, exp_rsp);
      end
    end else if (ao) ref_addr = d;
    else if (ref_addr[7:0] != 8'd0) ref_mem[ref_addr[7:0]] = d;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 256; i++) begin
      cpld_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.buffer_empty = 1'b0;
    rst = 1'b1;
    repeat (3) step;
    tests++;
    if ({cmd_ready, bus.rw, bus.ready, bus.addr, bus.data_oe, rsp_valid, irq} !== 7'b1100000) begin
      fails++;
      $display("FAIL reset flags: got %b required 1100000", {cmd_ready, bus.rw, bus.ready, bus.addr, bus.data_oe, rsp_valid, irq});
    end
    tests++;
    if ({rsp_data, bus.data_out} !== 32'h0) begin
      fails++;
      $display("FAIL reset data: rsp_data=%h data_out=%h required 0", rsp_data, bus.data_out);
    end
    rst = 1'b0;
    step;
  endtask
  task automatic test_write_addr;
    run_cmd(OP_WR_ADDR, 16'h0025, "wr_addr");
  endtask
  task automatic test_write_data;
    run_cmd(OP_WR_DATA, 16'hA5C3, "wr_data");
    tests++;
    if (cpld_mem[8'h25] !== 16'hA5C3) begin
      fails++;
      $display("FAIL cpld_latch: got %h required a5c3", cpld_mem[8'h25]);
    end
  endtask
  task automatic test_read_id;
    run_cmd(OP_WR_ADDR, 16'h0000, "wr_addr_id");
    run_cmd(OP_RD_DATA, 16'h1234, "rd_id");
    tests++;
    if (rsp_data !== 16'h0001) begin
      fails++;
      $display("FAIL device_id: got %h required 0001", rsp_data);
    end
  endtask
  task automatic test_back_to_back;
    run_cmd(OP_WR_ADDR, 16'h0033, "b2b_addr");
    run_cmd(OP_WR_DATA, 16'($urandom), "b2b_wr");
    run_cmd(OP_RD_ADDR, 16'h0000, "b2b_rd_addr");
    tests++;
    if (rsp_data !== 16'h0033) begin
      fails++;
      $display("FAIL b2b last_addr: got %h required 0033", rsp_data);
    end
    tests++;
    if (contention != 0) begin
      fails++;
      $display("FAIL contention cycles: got %0d required 0", contention);
    end
  endtask
  task automatic test_reset_mid;
    run_cmd(OP_WR_ADDR, 16'h0000, "mid_addr0");
    run_cmd(OP_RD_DATA, 16'h0000, "mid_rd");
    cmd_op = OP_WR_ADDR;
    cmd_data = 16'h0042;
    cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0;
    repeat (3) step;
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL mid strobe before rst: got %b required 1", bus.ready);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    tests++;
    if ({cmd_ready, bus.rw, bus.ready, bus.data_oe, rsp_valid} !== 5'b11000) begin
      fails++;
      $display("FAIL mid rst flags {ready,rw,strobe,oe,rsp_valid}: got %b required 11000", {cmd_ready, bus.rw, bus.ready, bus.data_oe, rsp_valid});
    end
    tests++;
    if (rsp_data !== 16'h0000) begin
      fails++;
      $display("FAIL mid rst rsp_data: got %h required 0000", rsp_data);
    end
    ref_addr = 16'h0042;
    for (int i = 0; i < 12; i++) begin
      step;
      tests++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL mid rst quiet cycle %0d: rsp_valid=%b cmd_ready=%b required 0/1", i, rsp_valid, cmd_ready);
      end
    end
    run_cmd(OP_RD_ADDR, 16'h0000, "mid_rd_addr");
  endtask
  task automatic test_random;
    logic [1:0] op;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      run_cmd(op, op == OP_WR_ADDR ? 16'($urandom_range(0, 15)) : 16'($urandom), "random");
    end
  endtask
  task automatic test_irq;
    int pulses;
    logic e;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      bus.buffer_empty = k < 5 || (k >= 15 && k < 20);
      e = k == 3 || k == 18;
      tests++;
      if (irq !== e) begin
        fails++;
        $display("FAIL irq cycle %0d: got %b required %b", k, irq, e);
      end
      if (irq === 1'b1) pulses++;
      step;
    end
    tests++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL irq pulses: got %0d required 2", pulses);
    end
  endtask
  initial begin
    test_reset;
    test_write_addr;
    test_write_data;
    test_read_id;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_irq;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
